branch_resolve_queue: RTL and testbench

BRANCH_RESOLVE_QUEUE -- requirements
Module: branch_resolve_queue

---
 rtl/branch_resolve_queue.sv | 108 ++++++++++
 tb/tb_branch_resolve_queue.sv | 148 ++++++++++++++
 2 files changed

// File: rtl/branch_resolve_queue.sv
// Branch resolve queue: holds the predicted branches that are still in flight,
// in program order. Resolves come back oldest-first and drive the predictor
// update. A mispredict flushes every younger entry, and the queue then spends
// one RECOVER cycle refusing pushes while fetch redirects.
module branch_resolve_queue #(
    parameter int DEPTH  = 4,
    parameter int W_PTR  = 2,
    parameter int W_BRID = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              push_i,
    input  logic              push_pred_i,
    input  logic [W_BRID-1:0] push_id_i,
    output logic              full_o,
    output logic              empty_o,
    output logic [W_PTR:0]    count_o,
    input  logic              res_v_i,
    input  logic              res_taken_i,
    output logic              upd_v_o,
    output logic              upd_branch_o,
    output logic [W_BRID-1:0] upd_id_o,
    output logic              mispredict_o,
    output logic              err_o
);

    typedef enum logic {RUN = 1'b0, RECOVER = 1'b1} state_t;

    localparam logic [W_PTR-1:0] PTR_ONE  = W_PTR'(1);
    localparam logic [W_PTR:0]   CNT_ONE  = (W_PTR+1)'(1);
    localparam logic [W_PTR:0]   CNT_FULL = (W_PTR+1)'(DEPTH);

    state_t            state_q;
    logic [W_PTR-1:0]  head_q, tail_q;
    logic              full_q;          // tells a full ring apart from an empty one when head == tail
    logic [DEPTH-1:0]  mem_pred;
    logic [W_BRID-1:0] mem_id [DEPTH];

    logic              res_ok, mis, push_ok, head_pred;
    logic [W_PTR:0]    cnt_nxt;

    // A full ring has head == tail, so the pointer difference is 0 and the flag supplies the top bit
    assign count_o   = {full_q, tail_q - head_q};
    assign empty_o   = (count_o == '0);
    assign full_o    = (count_o == CNT_FULL) || (state_q == RECOVER);
    assign head_pred = mem_pred[head_q];

    // Decide which resolve and which push actually take effect this cycle
    always_comb begin
        res_ok  = res_v_i && !empty_o;
        mis     = res_ok && (res_taken_i != head_pred);
        push_ok = push_i && (state_q == RUN) && !mis &&
                  ((count_o != CNT_FULL) || res_ok);
        cnt_nxt = count_o;
        if (push_ok && !res_ok)
            cnt_nxt = count_o + CNT_ONE;
        else if (!push_ok && res_ok)
            cnt_nxt = count_o - CNT_ONE;
    end

    // Entry storage; contents are meaningless once popped, so this array has no reset
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem_pred[tail_q] <= push_pred_i;
            mem_id[tail_q]   <= push_id_i;
        end
    end

    // Pointers, occupancy flag, the RUN/RECOVER machine and the registered outputs
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= RUN;
            head_q       <= '0;
            tail_q       <= '0;
            full_q       <= 1'b0;
            upd_v_o      <= 1'b0;
            upd_branch_o <= 1'b0;
            upd_id_o     <= '0;
            mispredict_o <= 1'b0;
            err_o        <= 1'b0;
        end else begin
            if (mis) begin
                // Pop the wrong branch and flush everything younger than it
                head_q  <= head_q + PTR_ONE;
                tail_q  <= head_q + PTR_ONE;
                full_q  <= 1'b0;
                state_q <= RECOVER;
            end else begin
                if (res_ok)  head_q <= head_q + PTR_ONE;
                if (push_ok) tail_q <= tail_q + PTR_ONE;
                full_q  <= (cnt_nxt == CNT_FULL);
                state_q <= RUN;
            end

            upd_v_o      <= res_ok;
            mispredict_o <= mis;
            if (res_ok) begin
                upd_branch_o <= res_taken_i;
                upd_id_o     <= mem_id[head_q];
            end

            // A resolve on an empty queue, or a push refused while in RUN, is a protocol error
            if ((res_v_i && empty_o) || (push_i && (state_q == RUN) && !push_ok))
                err_o <= 1'b1;
        end
    end

endmodule

// File: tb/tb_branch_resolve_queue.sv
// Directed bench for branch_resolve_queue with hand-computed expectations.
module tb_branch_resolve_queue;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       push_i = 1'b0, push_pred_i = 1'b0, res_v_i = 1'b0, res_taken_i = 1'b0;
    logic [1:0] push_id_i = '0;
    logic       full_o, empty_o, upd_v_o, upd_branch_o, mispredict_o, err_o;
    logic [2:0] count_o;
    logic [1:0] upd_id_o;

    int n_chk = 0;
    int n_err = 0;

    branch_resolve_queue #(.DEPTH(4), .W_PTR(2), .W_BRID(2)) dut (
        .clk(clk), .reset(reset),
        .push_i(push_i), .push_pred_i(push_pred_i), .push_id_i(push_id_i),
        .full_o(full_o), .empty_o(empty_o), .count_o(count_o),
        .res_v_i(res_v_i), .res_taken_i(res_taken_i),
        .upd_v_o(upd_v_o), .upd_branch_o(upd_branch_o), .upd_id_o(upd_id_o),
        .mispredict_o(mispredict_o), .err_o(err_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Apply one cycle of stimulus, sample 1ns after the rising edge, then go idle
    task automatic cyc(input logic p, input logic pp, input logic [1:0] id,
                       input logic r, input logic t);
        push_i = p; push_pred_i = pp; push_id_i = id; res_v_i = r; res_taken_i = t;
        @(posedge clk); #1;
        push_i = 1'b0; push_pred_i = 1'b0; push_id_i = '0; res_v_i = 1'b0; res_taken_i = 1'b0;
    endtask

    task automatic do_reset();
        reset = 1'b0; #1;
        chk("rst_count", 32'(count_o), 0);
        chk("rst_empty", 32'(empty_o), 1);
        chk("rst_err",   32'(err_o), 0);
        #1 reset = 1'b1;
    endtask

    initial begin
        // Reset state
        #1;
        chk("r_count", 32'(count_o), 0);
        chk("r_empty", 32'(empty_o), 1);
        chk("r_full",  32'(full_o), 0);
        chk("r_updv",  32'(upd_v_o), 0);
        chk("r_updb",  32'(upd_branch_o), 0);
        chk("r_updid", 32'(upd_id_o), 0);
        chk("r_mis",   32'(mispredict_o), 0);
        chk("r_err",   32'(err_o), 0);
        @(negedge clk); reset = 1'b1;

        // In-order resolve of three correctly predicted branches
        cyc(1, 1, 2'd3, 0, 0);
        cyc(1, 1, 2'd2, 0, 0);
        cyc(1, 1, 2'd1, 0, 0);
        chk("a_count3", 32'(count_o), 3);
        for (int k = 0; k < 3; k++) begin
            cyc(0, 0, 2'd0, 1, 1);
            chk("a_updv",  32'(upd_v_o), 1);
            chk("a_updid", 32'(upd_id_o), 32'(3 - k));
            chk("a_updb",  32'(upd_branch_o), 1);
            chk("a_mis",   32'(mispredict_o), 0);
        end
        cyc(0, 0, 2'd0, 0, 0);
        chk("a_updv0",  32'(upd_v_o), 0);
        chk("a_hold",   32'(upd_id_o), 1);
        chk("a_count0", 32'(count_o), 0);
        chk("a_empty",  32'(empty_o), 1);

        // Pointer wrap: one entry in flight, ten same-cycle push/resolve pairs
        cyc(1, 0, 2'd0, 0, 0);
        for (int i = 0; i < 10; i++) begin
            cyc(1, 0, 2'((i + 1) % 4), 1, 0);
            chk("w_updid", 32'(upd_id_o), 32'(i % 4));
            chk("w_count", 32'(count_o), 1);
            chk("w_mis",   32'(mispredict_o), 0);
        end
        cyc(0, 0, 2'd0, 1, 0);
        chk("w_last",   32'(upd_id_o), 2);
        chk("w_empty",  32'(empty_o), 1);
        chk("w_err",    32'(err_o), 0);

        // Full queue: push with pop accepted, push alone dropped with error
        for (int i = 0; i < 4; i++) cyc(1, 1, 2'(i), 0, 0);
        chk("f_full",  32'(full_o), 1);
        chk("f_count", 32'(count_o), 4);
        cyc(1, 1, 2'd3, 1, 1);
        chk("f_pp_count", 32'(count_o), 4);
        chk("f_pp_err",   32'(err_o), 0);
        chk("f_pp_id",    32'(upd_id_o), 0);
        cyc(1, 1, 2'd2, 0, 0);
        chk("f_drop_err",   32'(err_o), 1);
        chk("f_drop_count", 32'(count_o), 4);
        do_reset();

        // Mispredict with a same-cycle push: flush and one RECOVER cycle
        cyc(1, 1, 2'd1, 0, 0);
        cyc(1, 1, 2'd2, 0, 0);
        cyc(1, 1, 2'd3, 0, 0);
        cyc(1, 1, 2'd0, 1, 0);
        chk("m_mis",   32'(mispredict_o), 1);
        chk("m_updv",  32'(upd_v_o), 1);
        chk("m_updb",  32'(upd_branch_o), 0);
        chk("m_updid", 32'(upd_id_o), 1);
        chk("m_count", 32'(count_o), 0);
        chk("m_full",  32'(full_o), 1);
        cyc(1, 1, 2'd2, 0, 0);
        chk("m_full2",  32'(full_o), 0);
        chk("m_mis2",   32'(mispredict_o), 0);
        chk("m_count2", 32'(count_o), 0);
        do_reset();

        // Resolve on an empty queue
        cyc(0, 0, 2'd0, 1, 1);
        chk("u_updv", 32'(upd_v_o), 0);
        chk("u_err",  32'(err_o), 1);
        cyc(0, 0, 2'd0, 0, 0);
        chk("u_sticky", 32'(err_o), 1);
        do_reset();

        // Reset with two entries in flight
        cyc(1, 0, 2'd1, 0, 0);
        cyc(1, 0, 2'd2, 0, 0);
        chk("x_count2", 32'(count_o), 2);
        do_reset();
        chk("x_empty", 32'(empty_o), 1);
        for (int i = 0; i < 3; i++) begin
            cyc(0, 0, 2'd0, 0, 0);
            chk("x_updv", 32'(upd_v_o), 0);
            chk("x_count", 32'(count_o), 0);
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
